// File: rtl/mult_div_if.sv
// Operand/result bundle between the core and the HI/LO multiply/divide unit.
interface mult_div_if #(
    parameter int unsigned WIDTH = 32
);
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [2:0]       op;
    logic             start;
    logic             hilo_read;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
    logic             stall;

    // Core side: presents operands and requests, observes HI/LO and stall.
    modport master (
        output op_a, op_b, op, start, hilo_read,
        input  hi, lo, busy, done, stall
    );

    // Unit side.
    modport slave (
        input  op_a, op_b, op, start, hilo_read,
        output hi, lo, busy, done, stall
    );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit: shift-add multiply and restoring divide, one bit per
// cycle on magnitudes, with a sign fix-up cycle before HI/LO are written.
module mult_div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input logic        clk,
    input logic        rst,
    mult_div_if.slave  bus
);
    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    localparam logic [2:0] OpMult  = 3'b000;
    localparam logic [2:0] OpMultu = 3'b001;
    localparam logic [2:0] OpDiv   = 3'b010;
    localparam logic [2:0] OpDivu  = 3'b011;
    localparam logic [2:0] OpMthi  = 3'b100;
    localparam logic [2:0] OpMtlo  = 3'b101;

    typedef enum logic [1:0] {StIdle, StCalc, StFinish} state_e;

    state_e             state_q, state_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    // acc holds {partial product, multiplier} or {remainder, dividend/quotient}.
    logic [2*WIDTH-1:0] acc_q, acc_d;
    // Multiplicand or divisor magnitude.
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic               is_div_q, is_div_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;
    logic               div_zero_q, div_zero_d;

    // Operand decode at issue: even opcodes of the iterative group are signed.
    logic             is_signed, a_neg, b_neg;
    logic [WIDTH-1:0] mag_a, mag_b;

    assign is_signed = ~bus.op[0];
    assign a_neg     = is_signed & bus.op_a[WIDTH-1];
    assign b_neg     = is_signed & bus.op_b[WIDTH-1];
    assign mag_a     = a_neg ? (-bus.op_a) : bus.op_a;
    assign mag_b     = b_neg ? (-bus.op_b) : bus.op_b;

    // One multiply step: conditionally add multiplicand to the upper half, then shift right.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;

    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // One restoring divide step: shift in next dividend bit, subtract if it fits.
    logic [WIDTH:0]     div_shift, div_diff;
    logic               div_ge;
    logic [WIDTH-1:0]   div_rem;
    logic [2*WIDTH-1:0] div_next;

    assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, opnd_q};
    assign div_ge    = ~div_diff[WIDTH];
    assign div_rem   = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
    assign div_next  = {div_rem, acc_q[WIDTH-2:0], div_ge};

    // Sign fix-up of the finished magnitude result.
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    assign prod_fix = neg_res_q ? (-acc_q) : acc_q;
    assign quo_fix  = neg_res_q ? (-acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
    assign rem_fix  = neg_rem_q ? (-acc_q[2*WIDTH-1:WIDTH]) : acc_q[2*WIDTH-1:WIDTH];

    // Next-state logic for the FSM, datapath and HI/LO.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        acc_d      = acc_q;
        opnd_d     = opnd_q;
        is_div_d   = is_div_q;
        neg_res_d  = neg_res_q;
        neg_rem_d  = neg_rem_q;
        div_zero_d = div_zero_q;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    case (bus.op)
                        OpMthi: hi_d = bus.op_a;
                        OpMtlo: lo_d = bus.op_a;
                        OpMult, OpMultu, OpDiv, OpDivu: begin
                            acc_d      = {{WIDTH{1'b0}}, mag_a};
                            opnd_d     = mag_b;
                            is_div_d   = bus.op[1];
                            neg_res_d  = a_neg ^ b_neg;
                            neg_rem_d  = a_neg;
                            div_zero_d = (bus.op_b == '0);
                            cnt_d      = '0;
                            busy_d     = 1'b1;
                            state_d    = StCalc;
                        end
                        default: ;
                    endcase
                end
            end
            StCalc: begin
                acc_d = is_div_q ? div_next : mul_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LastCnt) begin
                    state_d = StFinish;
                end
            end
            StFinish: begin
                if (is_div_q) begin
                    hi_d = rem_fix;
                    lo_d = div_zero_q ? '1 : quo_fix;
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers; synchronous reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            acc_q      <= '0;
            opnd_q     <= '0;
            is_div_q   <= 1'b0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            acc_q      <= acc_d;
            opnd_q     <= opnd_d;
            is_div_q   <= is_div_d;
            neg_res_q  <= neg_res_d;
            neg_rem_q  <= neg_rem_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.stall = busy_q & (bus.start | bus.hilo_read);

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit with hand-computed HI/LO results.
module tb_mult_div_unit;
    localparam int unsigned W = 32;

    localparam logic [2:0] OpMult  = 3'b000;
    localparam logic [2:0] OpMultu = 3'b001;
    localparam logic [2:0] OpDiv   = 3'b010;
    localparam logic [2:0] OpDivu  = 3'b011;
    localparam logic [2:0] OpMthi  = 3'b100;
    localparam logic [2:0] OpMtlo  = 3'b101;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    mult_div_if #(.WIDTH(W)) bus ();

    mult_div_unit #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one iterative op and wait for done; checks latency, busy length and optional stall.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input bit with_read, input bit with_mthi);
        int edges;
        int busy_cnt;
        bus.op        = o;
        bus.op_a      = a;
        bus.op_b      = b;
        bus.start     = 1'b1;
        bus.hilo_read = with_read;
        tick();
        bus.start = 1'b0;
        edges     = 0;
        busy_cnt  = 0;
        if (bus.busy) busy_cnt++;
        if (with_read) check({tag, "_stall_first"}, 64'(bus.stall), 64'(1));
        while (!bus.done && edges < 100) begin
            if (with_mthi && edges == 5) begin
                bus.op    = OpMthi;
                bus.op_a  = 32'h0000_00AA;
                bus.start = 1'b1;
            end
            tick();
            bus.start = 1'b0;
            edges++;
            if (bus.busy) busy_cnt++;
            if (with_read) begin
                if (bus.done) check({tag, "_stall_done"}, 64'(bus.stall), 64'(0));
                else          check({tag, "_stall_busy"}, 64'(bus.stall), 64'(1));
            end
        end
        bus.hilo_read = 1'b0;
        // done lands on the 34th edge counting the start edge itself.
        check({tag, "_latency"}, 64'(edges), 64'(33));
        check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(33));
    endtask

    task automatic check_result(input string tag, input logic [31:0] hi_e, input logic [31:0] lo_e);
        check({tag, "_hi"}, 64'(bus.hi), 64'(hi_e));
        check({tag, "_lo"}, 64'(bus.lo), 64'(lo_e));
        tick();
        check({tag, "_done_clear"}, 64'(bus.done), 64'(0));
    endtask

    initial begin
        int done_seen;
        n_cmp         = 0;
        n_err         = 0;
        rst           = 1'b1;
        bus.op        = 3'b000;
        bus.op_a      = '0;
        bus.op_b      = '0;
        bus.start     = 1'b0;
        bus.hilo_read = 1'b0;
        tick();
        tick();
        check("rst_hi", 64'(bus.hi), 64'(0));
        check("rst_lo", 64'(bus.lo), 64'(0));
        check("rst_busy", 64'(bus.busy), 64'(0));
        check("rst_done", 64'(bus.done), 64'(0));
        check("rst_stall", 64'(bus.stall), 64'(0));
        rst = 1'b0;
        tick();

        run_op("mult_neg", OpMult, 32'hFFFF_FFFD, 32'd7, 1'b0, 1'b0);
        check_result("mult_neg", 32'hFFFF_FFFF, 32'hFFFF_FFEB);

        run_op("multu_max", OpMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        check_result("multu_max", 32'hFFFF_FFFE, 32'h0000_0001);

        run_op("divu_100_7", OpDivu, 32'd100, 32'd7, 1'b0, 1'b0);
        check_result("divu_100_7", 32'h0000_0002, 32'h0000_000E);

        run_op("div_m7_2", OpDiv, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
        check_result("div_m7_2", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        run_op("div_ovf", OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        check_result("div_ovf", 32'h0000_0000, 32'h8000_0000);

        run_op("divu_by0", OpDivu, 32'h0000_1234, 32'd0, 1'b0, 1'b0);
        check_result("divu_by0", 32'h0000_1234, 32'hFFFF_FFFF);

        run_op("div_by0", OpDiv, 32'h0000_1234, 32'd0, 1'b0, 1'b0);
        check_result("div_by0", 32'h0000_1234, 32'hFFFF_FFFF);

        // 0x10000 * 0x10000 = 0x1_0000_0000; an MTHI of 0xAA while busy must not land.
        run_op("mult_stall", OpMult, 32'h0001_0000, 32'h0001_0000, 1'b1, 1'b1);
        check_result("mult_stall", 32'h0000_0001, 32'h0000_0000);

        // MTLO while idle: single cycle, no busy, no done.
        bus.op    = OpMtlo;
        bus.op_a  = 32'h0000_0055;
        bus.start = 1'b1;
        check("mtlo_stall_idle", 64'(bus.stall), 64'(0));
        tick();
        bus.start = 1'b0;
        check("mtlo_lo", 64'(bus.lo), 64'(32'h55));
        check("mtlo_hi_hold", 64'(bus.hi), 64'(32'h1));
        check("mtlo_busy", 64'(bus.busy), 64'(0));
        check("mtlo_done", 64'(bus.done), 64'(0));

        // MTHI while idle.
        bus.op    = OpMthi;
        bus.op_a  = 32'h0000_0077;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("mthi_hi", 64'(bus.hi), 64'(32'h77));
        check("mthi_lo_hold", 64'(bus.lo), 64'(32'h55));

        // Undefined op leaves everything alone.
        bus.op    = 3'b110;
        bus.op_a  = 32'hDEAD_BEEF;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("undef_hi", 64'(bus.hi), 64'(32'h77));
        check("undef_lo", 64'(bus.lo), 64'(32'h55));
        check("undef_busy", 64'(bus.busy), 64'(0));

        // Reset at CALC iteration 10 of a DIVU.
        bus.op    = OpDivu;
        bus.op_a  = 32'd1000;
        bus.op_b  = 32'd3;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (10) tick();
        check("abort_busy_pre", 64'(bus.busy), 64'(1));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_hi", 64'(bus.hi), 64'(0));
        check("abort_lo", 64'(bus.lo), 64'(0));
        check("abort_busy", 64'(bus.busy), 64'(0));
        check("abort_done", 64'(bus.done), 64'(0));
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.done) done_seen++;
        end
        check("abort_no_done", 64'(done_seen), 64'(0));

        run_op("multu_3x5", OpMultu, 32'd3, 32'd5, 1'b0, 1'b0);
        check_result("multu_3x5", 32'h0000_0000, 32'h0000_000F);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
